// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus port between instruction fetch and the LSU,
// with LSU priority and a bounded-starvation override for fetch.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                lsu_req_i,
  input  logic                lsu_we_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_be_i,
  output logic                lsu_gnt_o,
  output logic                lsu_rvalid_o,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic                mem_ready_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                if_stall_o,
  output logic                lsu_stall_o
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  typedef enum logic [1:0] {IDLE, IF_ACT, LSU_ACT} state_e;
  state_e            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              if_gnt_q, if_gnt_d, lsu_gnt_q, lsu_gnt_d;
  logic              if_rvalid_q, if_rvalid_d, lsu_rvalid_q, lsu_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, lsu_rdata_q, lsu_rdata_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic              if_win;
  assign if_win = if_req_i & (~lsu_req_i | (starve_q == SMAX));
  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    if_gnt_d     = 1'b0;
    lsu_gnt_d    = 1'b0;
    if_rvalid_d  = 1'b0;
    lsu_rvalid_d = 1'b0;
    if_rdata_d   = if_rdata_q;
    lsu_rdata_d  = lsu_rdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    if (state_q == IDLE) begin
      if (if_req_i | lsu_req_i) begin
        state_d     = if_win ? IF_ACT : LSU_ACT;
        if_gnt_d    = if_win;
        lsu_gnt_d   = ~if_win;
        mem_req_d   = 1'b1;
        mem_we_d    = ~if_win & lsu_we_i;
        mem_addr_d  = if_win ? if_addr_i : lsu_addr_i;
        mem_wdata_d = if_win ? '0 : lsu_wdata_i;
        mem_be_d    = if_win ? '1 : lsu_be_i;
        starve_d    = if_win ? 4'd0 : (if_req_i && starve_q != SMAX) ? starve_q + 4'd1 : starve_q;
      end
    end else if (mem_ready_i) begin
      state_d      = IDLE;
      mem_req_d    = 1'b0;
      if_rvalid_d  = state_q == IF_ACT;
      lsu_rvalid_d = state_q == LSU_ACT;
      if_rdata_d   = state_q == IF_ACT ? mem_rdata_i : if_rdata_q;
      lsu_rdata_d  = state_q == LSU_ACT ? mem_rdata_i : lsu_rdata_q;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      if_gnt_q     <= 1'b0;
      lsu_gnt_q    <= 1'b0;
      if_rvalid_q  <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      if_rdata_q   <= '0;
      lsu_rdata_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      if_gnt_q     <= if_gnt_d;
      lsu_gnt_q    <= lsu_gnt_d;
      if_rvalid_q  <= if_rvalid_d;
      lsu_rvalid_q <= lsu_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      lsu_rdata_q  <= lsu_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
    end
  end
  assign if_gnt_o     = if_gnt_q;
  assign lsu_gnt_o    = lsu_gnt_q;
  assign if_rvalid_o  = if_rvalid_q;
  assign lsu_rvalid_o = lsu_rvalid_q;
  assign if_rdata_o   = if_rdata_q;
  assign lsu_rdata_o  = lsu_rdata_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_be_o     = mem_be_q;
  assign if_stall_o   = if_req_i & ~if_rvalid_q;
  assign lsu_stall_o  = lsu_req_i & ~lsu_rvalid_q;
endmodule
